// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver: 2-flop sync, 16x oversampling, 3-sample majority per bit.
// Pulses fire combinationally on the deciding tick (start +10 ticks, byte/error +154); no backpressure.
module uart_rx_sampler #(
  parameter int TICK_DIV   = 26,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_byte,
  output logic       rx_start,
  output logic       rx_complete,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MID = OVERSAMPLE / 2;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t          state, state_nxt;
  logic            sync1, s, s_d;
  logic [TW-1:0]   tick_cnt;
  logic            tick, start_edge, decide, maj;
  logic            samp_a, samp_b;
  logic [3:0]      samp_cnt, bit_idx;
  logic [7:0]      shreg, byte_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      s_d   <= 1'b0;
    end else begin
      sync1 <= rx_in;
      s     <= sync1;
      s_d   <= s;
    end
  end

  assign tick       = (tick_cnt == TW'(TICK_DIV - 1));
  assign start_edge = (state == IDLE) && s_d && !s;
  // Third sample is the live synchronizer output on the deciding tick.
  assign decide     = tick && (samp_cnt == 4'(MID + 1));
  assign maj        = (samp_a & samp_b) | (samp_a & s) | (samp_b & s);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (start_edge || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      samp_cnt <= 4'd0;
      bit_idx  <= 4'd0;
    end else if (state == IDLE) begin
      samp_cnt <= 4'd0;
      bit_idx  <= 4'd0;
    end else if (tick) begin
      if (samp_cnt == 4'(OVERSAMPLE - 1)) begin
        samp_cnt <= 4'd0;
        bit_idx  <= bit_idx + 4'd1;
      end else begin
        samp_cnt <= samp_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      samp_a <= 1'b0;
      samp_b <= 1'b0;
    end else if (tick) begin
      if (samp_cnt == 4'(MID - 1)) samp_a <= s;
      if (samp_cnt == 4'(MID))     samp_b <= s;
    end
  end

  // LSB arrives first, so shifting right leaves data bit k-1 at position k-1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg <= 8'h00;
    end else if (state == DATA && decide) begin
      shreg <= {maj, shreg[7:1]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_q <= 8'h00;
    end else if (rx_complete) begin
      byte_q <= shreg;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    rx_start     = 1'b0;
    rx_complete  = 1'b0;
    rx_frame_err = 1'b0;
    case (state)
      IDLE:  if (start_edge) state_nxt = START;
      START: begin
        if (decide) begin
          if (maj) begin
            state_nxt = IDLE;
          end else begin
            rx_start  = 1'b1;
            state_nxt = DATA;
          end
        end
      end
      DATA:  if (decide && bit_idx == 4'd8) state_nxt = STOP;
      STOP: begin
        if (decide) begin
          if (maj) begin
            rx_complete = 1'b1;
            state_nxt   = IDLE;
          end else begin
            rx_frame_err = 1'b1;
            state_nxt    = BRK;
          end
        end
      end
      // Stay here until the line releases so a held break yields one error only.
      BRK:   if (s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rx_byte = rx_complete ? shreg : byte_q;
  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: frames are generated cycle by cycle, expected pulses
// are queued per frame and a negedge monitor pops and compares them.
module tb_uart_rx_sampler;

  localparam int TD      = 26;
  localparam int BP      = 16 * TD;
  localparam int K_START = 0;
  localparam int K_DONE  = 1;
  localparam int K_FERR  = 2;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] dat;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  int         mon_kind;
  logic       clock = 1'b0;
  logic       reset;
  logic       rx_in;
  logic [7:0] rx_byte;
  logic       rx_start, rx_complete, rx_frame_err, rx_busy;
  int         cyc = 0;
  int         total = 0;
  int         passed = 0;
  logic [7:0] model_byte = 8'h00;

  uart_rx_sampler #(.TICK_DIV(TD), .OVERSAMPLE(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_in        (rx_in),
    .rx_byte      (rx_byte),
    .rx_start     (rx_start),
    .rx_complete  (rx_complete),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_ev(input int kind, input int c, input logic [7:0] d);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.dat  = d;
    exp_q.push_back(e);
  endtask

  // Receiver timing is anchored to the fall: edge seen 2 cycles later (E),
  // decisions at E + ticks*TD. Noise flips the line for the single cycle that
  // the receiver samples as one of the three votes of a bit.
  task automatic send_frame(input logic [7:0] b, input int bp, input logic stop_bit,
                            input bit noise, input int rst_at, input bit chk_busy);
    logic [9:0] bits;
    int         nz[10];
    int         f;
    logic       lvl;
    bits = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++)
      nz[k] = noise ? (16 * k + 8 + int'($urandom_range(0, 2))) * TD : -1;
    f = cyc;
    push_ev(K_START, f + 2 + 10 * TD, 8'h00);
    if (rst_at < 0) begin
      if (stop_bit) begin
        model_byte = b;
        push_ev(K_DONE, f + 2 + 154 * TD, b);
      end else begin
        push_ev(K_FERR, f + 2 + 154 * TD, model_byte);
      end
    end
    for (int c = 0; c < 10 * bp; c++) begin
      lvl = bits[c / bp];
      for (int k = 0; k < 10; k++)
        if (nz[k] == c) lvl = ~lvl;
      rx_in = lvl;
      if (c == rst_at) begin
        reset = 1'b1;
        model_byte = 8'h00;
        #1;
        chk("async_reset_byte", rx_byte, 0);
        chk("async_reset_busy", rx_busy, 0);
        chk("async_reset_pulses", {rx_start, rx_complete, rx_frame_err}, 0);
      end
      if (c == rst_at + 1) reset = 1'b0;
      if (chk_busy) begin
        if (c == 2)    chk("busy_at_E", rx_busy, 0);
        if (c == 3)    chk("busy_at_E+1", rx_busy, 1);
        if (c == 4006) chk("busy_at_E+4004", rx_busy, 1);
        if (c == 4007) chk("busy_at_E+4005", rx_busy, 0);
      end
      @(negedge clock);
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (!reset && (rx_start || rx_complete || rx_frame_err)) begin
      chk("single_pulse", int'(rx_start) + int'(rx_complete) + int'(rx_frame_err), 1);
      mon_kind = rx_start ? K_START : (rx_complete ? K_DONE : K_FERR);
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, required no pulse", mon_kind, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pulse_kind", mon_kind, mon_e.kind);
        chk("pulse_cycle", cyc, mon_e.cyc);
        if (mon_kind != K_START) chk("pulse_rx_byte", rx_byte, mon_e.dat);
      end
    end
  end

  initial begin
    logic [7:0] rb;
    int         bp, gap;
    bit         nz;
    reset = 1'b1;
    rx_in = 1'b0;
    repeat (5) @(negedge clock);
    chk("reset_rx_byte", rx_byte, 0);
    chk("reset_busy", rx_busy, 0);
    chk("reset_pulses", {rx_start, rx_complete, rx_frame_err}, 0);
    reset = 1'b0;
    repeat (600) @(negedge clock);
    chk("held_low_no_start", rx_busy, 0);
    idle(50);

    send_frame(8'hA5, BP, 1'b1, 1'b0, -1, 1'b1);
    idle(100);

    send_frame(8'h00, BP, 1'b1, 1'b0, -1, 1'b0);
    send_frame(8'hFF, BP, 1'b1, 1'b0, -1, 1'b0);
    send_frame(8'h55, 404, 1'b1, 1'b0, -1, 1'b0);
    idle(100);

    for (int c = 0; c < 2 * BP; c++) begin
      rx_in = (c < 3 * TD) ? 1'b0 : 1'b1;
      if (c == 3)   chk("glitch_busy_entered", rx_busy, 1);
      if (c == 263) chk("glitch_back_idle", rx_busy, 0);
      @(negedge clock);
    end

    send_frame(8'h3C, BP, 1'b1, 1'b1, -1, 1'b0);
    idle(100);

    send_frame(8'h81, BP, 1'b0, 1'b0, -1, 1'b0);
    rx_in = 1'b0;
    repeat (20 * BP) @(negedge clock);
    chk("break_busy", rx_busy, 1);
    idle(2 * BP);
    chk("break_released", rx_busy, 0);
    send_frame(8'h42, BP, 1'b1, 1'b0, -1, 1'b0);
    idle(100);
    chk("byte_after_break", rx_byte, model_byte);

    rb = 8'($urandom_range(0, 15)) | 8'hF0;
    send_frame(rb, BP, 1'b1, 1'b0, 5 * BP + BP / 2, 1'b0);
    idle(100);
    send_frame(8'h7E, BP, 1'b1, 1'b0, -1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       bp = 404;
        1:       bp = 416;
        default: bp = 428;
      endcase
      nz  = 1'($urandom_range(0, 1));
      gap = int'($urandom_range(0, 150));
      send_frame(rb, bp, 1'b1, nz, -1, 1'b0);
      idle(gap);
    end

    idle(200);
    chk("all_expected_pulses_seen", exp_q.size(), 0);
    chk("rx_byte_holds", rx_byte, model_byte);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
